// File: rtl/seq_payload_capture_if.sv
// Signal bundle between the sync-pattern detector/serial stream, the payload
// capture stage and the word consumer.
interface seq_payload_capture_if #(
  parameter int DATA_W = 8
);
  logic              bit_in;
  logic              match;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              overflow;
  logic [15:0]       frame_cnt;

  // master: the capture stage producing words; slave: stream source plus consumer
  modport master (
    input  bit_in, match, data_ready,
    output data_out, data_valid, busy, overflow, frame_cnt
  );

  modport slave (
    output bit_in, match, data_ready,
    input  data_out, data_valid, busy, overflow, frame_cnt
  );
endinterface

// File: rtl/seq_payload_capture.sv
// Deserializes the DATA_W bits following each detected sync pattern (MSB first)
// and buffers the words in a show-ahead FIFO with a valid/ready output.
module seq_payload_capture #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_payload_capture_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_bit_d;
  logic [DATA_W-2:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_shift;
  logic              w_push;
  logic [DATA_W-1:0] w_word;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_overflow;
  logic [15:0]       r_frame_cnt;
  logic              w_full;
  logic              w_pop;
  logic              w_wr;

  // match arrives one cycle late, so the payload is taken from the delayed bit
  assign w_word = {r_shreg, r_bit_d};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_shift      = 1'b0;
    w_push       = 1'b0;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.match) begin
          w_shift      = 1'b1;
          w_cnt_next   = CNT_W'(1);
          w_next_state = RECV;
        end
      end
      RECV: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_push       = 1'b1;
          w_cnt_next   = '0;
          w_next_state = IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_d <= 1'b0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_bit_d <= bus.bit_in;
      r_cnt   <= w_cnt_next;
      if (w_shift) begin
        r_shreg <= w_word[DATA_W-2:0];
      end
    end
  end

  assign w_full = (r_count == DEPTH_C);
  assign w_pop  = (r_count != '0) && bus.data_ready;
  // a pop frees the slot in the same edge, so a full FIFO still accepts the push
  assign w_wr   = w_push && (!w_full || w_pop);

  // NOTE: the storage is reset because data_out must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_word;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_frame_cnt     <= r_frame_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.data_out   = r_mem[r_rd_ptr];
  assign bus.data_valid = (r_count != '0);
  assign bus.busy       = (r_state == RECV);
  assign bus.overflow   = r_overflow;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_seq_payload_capture.sv
// Bench for seq_payload_capture: serial stream plus a sync detector model drive
// the DUT; a word-level reference model is compared against the outputs every cycle.
module tb_seq_payload_capture;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_payload_capture_if #(.DATA_W(DATA_W)) bus ();

  seq_payload_capture #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sync detector model: registered pulse one edge after the last pattern bit
  logic [7:0] det_sr;
  logic       det_match;
  logic       man_match = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_sr    <= 8'h00;
      det_match <= 1'b0;
    end else begin
      det_sr    <= {det_sr[6:0], bus.bit_in};
      det_match <= (det_sr == 8'h71);
    end
  end
  assign bus.match = det_match | man_match;

  // Reference model: a frame is "bits still to collect"; output is a word queue
  logic [7:0]  m_q[$];
  int          m_left = 0;
  int          m_word = 0;
  logic        m_prev_bit = 1'b0;
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = 16'd0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_left     = 0;
      m_word     = 0;
      m_prev_bit = 1'b0;
      m_ovf      = 1'b0;
      m_cnt      = 16'd0;
    end else begin
      bit do_pop, do_push;
      do_pop  = (m_q.size() != 0) && bus.data_ready;
      do_push = 1'b0;
      if (m_left == 0) begin
        if (bus.match) begin
          m_word = int'(m_prev_bit);
          m_left = DATA_W - 1;
        end
      end else begin
        m_word = m_word * 2 + int'(m_prev_bit);
        m_left = m_left - 1;
        do_push = (m_left == 0);
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        if (m_q.size() == DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          m_q.push_back(8'(m_word));
          m_cnt = m_cnt + 16'd1;
        end
      end
      m_prev_bit = bus.bit_in;
    end
  end

  // Observed pops and edge counter
  logic [7:0] got[$];
  logic [7:0] exp_w[$];
  int cyc = 0;
  int e_cyc = -1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got.delete();
      cyc   = 0;
      e_cyc = -1;
    end else begin
      cyc++;
      if (bus.data_valid && bus.data_ready) got.push_back(bus.data_out);
      if (bus.match && e_cyc < 0) e_cyc = cyc;
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle
  int busy_cyc = 0;
  int valid_cyc = 0;
  int v_cyc = -1;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cyc  = 0;
      valid_cyc = 0;
      v_cyc     = -1;
    end else begin
      check("data_valid", 32'(bus.data_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check("data_out", 32'(bus.data_out), 32'(m_q[0]));
      check("busy", 32'(bus.busy), 32'(m_left != 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
      if (bus.busy) busy_cyc++;
      if (bus.data_valid) begin
        valid_cyc++;
        if (v_cyc < 0) v_cyc = cyc;
      end
    end
  end

  logic rdy_base = 1'b0;
  logic rand_rdy = 1'b0;

  task automatic drive_slot(input logic b, input logic m, input logic force_rdy);
    bus.bit_in     = b;
    man_match      = m;
    bus.data_ready = force_rdy ? 1'b1 : (rand_rdy ? 1'($urandom_range(0, 1)) : rdy_base);
    @(posedge clk);
    #1;
  endtask

  // Slot j of v (MSB first) is sampled at the j-th edge after the call
  task automatic send_stream(input logic [23:0] v, input int n, input logic [23:0] mm,
                             input int rdy_slot);
    for (int j = 0; j < n; j++) drive_slot(v[23-j], mm[23-j], j == rdy_slot);
    man_match = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) drive_slot(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.bit_in     = 1'b0;
    bus.data_ready = 1'b0;
    man_match      = 1'b0;
    rand_rdy       = 1'b0;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_words(input string nm);
    check({nm, " count"}, 32'(got.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size(); i++)
      check($sformatf("%s[%0d]", nm, i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD_BEEF,
            32'(exp_w[i]));
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, " data_valid"}, 32'(bus.data_valid), 32'd0);
    check({nm, " data_out"}, 32'(bus.data_out), 32'd0);
    check({nm, " busy"}, 32'(bus.busy), 32'd0);
    check({nm, " overflow"}, 32'(bus.overflow), 32'd0);
    check({nm, " frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] v;
    logic [23:0] mm;

    bus.bit_in     = 1'b0;
    bus.data_ready = 1'b0;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame: pattern then 1010_0110
    rdy_base = 1'b1;
    send_stream({8'h71, 8'hA6, 8'h00}, 24, 24'h0, -1);
    idle(4);
    exp_w = '{8'hA6};
    check_words("single words");
    check("single frame_cnt", 32'(bus.frame_cnt), 32'd1);
    check("single busy cycles", 32'(busy_cyc), 32'd7);
    check("single valid cycles", 32'(valid_cyc), 32'd1);
    check("single latency", 32'(v_cyc - e_cyc), 32'd7);

    // match pulses inside RECV, including the word-completing edge, are ignored
    do_reset();
    rdy_base = 1'b1;
    send_stream({8'h71, 8'h5A, 8'h00}, 24, (24'h1 << 11) | (24'h1 << 7), -1);
    idle(4);
    exp_w = '{8'h5A};
    check_words("recv_match words");
    check("recv_match frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Back-to-back: second match exactly DATA_W edges after the first
    do_reset();
    rdy_base = 1'b1;
    send_stream({8'h71, 8'hFF, 8'h00}, 24, 24'h1 << 6, -1);
    idle(12);
    exp_w = '{8'hFF, 8'h00};
    check_words("b2b words");
    check("b2b frame_cnt", 32'(bus.frame_cnt), 32'd2);

    // Backpressure: fifth word dropped
    do_reset();
    rdy_base = 1'b0;
    for (int p = 1; p <= 5; p++) send_stream({8'h71, 8'(p), 8'h00}, 24, 24'h0, -1);
    check("ovf flag", 32'(bus.overflow), 32'd1);
    check("ovf frame_cnt", 32'(bus.frame_cnt), 32'd4);
    check("ovf nothing popped", 32'(got.size()), 32'd0);
    rdy_base = 1'b1;
    idle(8);
    exp_w = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_words("ovf drain");
    check("ovf sticky", 32'(bus.overflow), 32'd1);
    check("ovf frame_cnt after", 32'(bus.frame_cnt), 32'd4);

    // Full FIFO with a pop on the word-completing edge
    do_reset();
    rdy_base = 1'b0;
    send_stream({8'h71, 8'h11, 8'h00}, 24, 24'h0, -1);
    send_stream({8'h71, 8'h22, 8'h00}, 24, 24'h0, -1);
    send_stream({8'h71, 8'h33, 8'h00}, 24, 24'h0, -1);
    send_stream({8'h71, 8'h44, 8'h00}, 24, 24'h0, -1);
    send_stream({8'h71, 8'h55, 8'h00}, 24, 24'h0, 16);
    check("fullpop overflow", 32'(bus.overflow), 32'd0);
    check("fullpop frame_cnt", 32'(bus.frame_cnt), 32'd5);
    rdy_base = 1'b1;
    idle(8);
    exp_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check_words("fullpop order");

    // Async reset three bits into a payload
    do_reset();
    rdy_base = 1'b0;
    send_stream({8'h71, 8'h99, 8'h00}, 24, 24'h0, -1);
    send_stream({8'h71, 8'hE0, 8'h00}, 11, 24'h0, -1);
    check("midreset busy before", 32'(bus.busy), 32'd1);
    bus.bit_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_base = 1'b1;
    send_stream({8'h71, 8'h3C, 8'h00}, 24, 24'h0, -1);
    idle(4);
    exp_w = '{8'h3C};
    check_words("midreset words");
    check("midreset frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Randomized frames, ready patterns and stray match pulses
    do_reset();
    for (int it = 0; it < 40; it++) begin
      rdy_base = 1'($urandom_range(0, 1));
      rand_rdy = 1'($urandom_range(0, 1));
      v = {8'h71, 8'($urandom), 8'($urandom)};
      if (it % 10 == 3) v[15:8] = 8'h71;
      mm = ($urandom_range(0, 3) == 0) ? (24'h1 << $urandom_range(0, 23)) : 24'h0;
      send_stream(v, 24, mm, -1);
      idle($urandom_range(0, 3));
    end
    rand_rdy = 1'b0;
    rdy_base = 1'b1;
    idle(16);
    check("random drained", 32'(bus.data_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
